mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master (CPU, loader) round-robin arbiter in front of a single-port
//   memory. Each granted access runs IDLE -> ADDR -> DATA -> DONE, one cycle
//   per state. Address, write data and access type are captured at the grant
//   and held for the whole access. The owner's ack pulses in DONE.
//
// Ports
//   clk, rst_                 clock, asynchronous active-low reset
//   cpu_rd/wr/addr/wdata      CPU request (rd+wr together means write)
//   cpu_ack                   one-cycle completion pulse to the CPU
//   ld_rd/wr/addr/wdata       loader request (rd+wr together means write)
//   ld_ack                    one-cycle completion pulse to the loader
//   rdata                     registered read data, valid during ack
//   mem_rd/wr/addr/wdata      memory strobes, address and write data
//   mem_rdata                 memory read data
//   busy                      high whenever the FSM is not in IDLE
//
// Parameter
//   RR_RESET_LAST             last-owner value after reset (1 = loader,
//                             so the CPU wins the first tie)
module mem_bus_arbiter #(
  parameter logic RR_RESET_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  input  logic       ld_rd,
  input  logic       ld_wr,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_wdata,
  output logic       ld_ack,
  output logic [7:0] rdata,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_owner;       // 0 = CPU, 1 = loader
  logic       r_last_owner;
  logic       r_is_write;
  logic [4:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic [7:0] r_rdata;

  logic       w_cpu_req;
  logic       w_ld_req;
  logic       w_grant_ld;
  logic       w_start;

  assign w_cpu_req = cpu_rd | cpu_wr;
  assign w_ld_req  = ld_rd | ld_wr;

  // On a tie the requester that did not own the previous access wins.
  assign w_grant_ld = (w_cpu_req && w_ld_req) ? ~r_last_owner : w_ld_req;
  assign w_start    = (r_state == IDLE) && (w_cpu_req || w_ld_req);

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next_state = ADDR;
      ADDR:    w_next_state = DATA;
      DATA:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Access bookkeeping: grant capture, read-data capture, round-robin history
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_owner      <= 1'b0;
      r_last_owner <= RR_RESET_LAST;
      r_is_write   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_grant_ld;
        if (w_grant_ld) begin
          r_mem_addr  <= ld_addr;
          r_mem_wdata <= ld_wdata;
          r_is_write  <= ld_wr;
        end else begin
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
          r_is_write  <= cpu_wr;
        end
      end
      if ((r_state == DATA) && !r_is_write) begin
        r_rdata <= mem_rdata;
      end
      if (r_state == DONE) begin
        r_last_owner <= r_owner;
      end
    end
  end

  // Outputs decoded from state; reset forces IDLE, so strobes and acks drop
  // asynchronously with rst_.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    cpu_ack = 1'b0;
    ld_ack  = 1'b0;
    unique case (r_state)
      IDLE: ;
      ADDR: mem_rd = ~r_is_write;
      DATA: begin
        mem_rd = ~r_is_write;
        mem_wr = r_is_write;
      end
      DONE: begin
        cpu_ack = ~r_owner;
        ld_ack  = r_owner;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Scoreboard bench for mem_bus_arbiter. A transaction-level reference model
//   decides grants from the request inputs (round robin, one access per four
//   cycles) and pushes the expected access into a queue; a monitor compares
//   the DUT's strobes, address/data, busy, acks and rdata against the queue
//   head every cycle. Directed sequences cover reset, single accesses, ties,
//   mid-access disturbance and reset mid-access; a randomized phase follows.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_;
  logic       cpu_rd, cpu_wr, ld_rd, ld_wr;
  logic [4:0] cpu_addr, ld_addr;
  logic [7:0] cpu_wdata, ld_wdata;
  logic       cpu_ack, ld_ack;
  logic [7:0] rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;

  mem_bus_arbiter #(.RR_RESET_LAST(1'b1)) dut (
    .clk(clk), .rst_(rst_),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .ld_rd(ld_rd), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack),
    .rdata(rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // External memory seen by the DUT
  logic [7:0] tbmem [32];
  assign mem_rdata = tbmem[mem_addr];
  initial forever begin
    @(posedge clk);
    if (mem_wr) tbmem[mem_addr] <= mem_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         ack_at;   // cycle index (posedge count) whose following cycle carries the ack
    logic       who;      // 0 CPU, 1 loader
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] refmem [32];
  int         cyc = 0;
  bit         inflight = 0;
  exp_t       cur;
  logic       last_owner_m = 1'b1;
  logic [7:0] last_rd_m = 8'h00;

  initial forever begin
    bit creq, lreq;
    logic who;
    @(posedge clk);
    cyc++;
    if (rst_ === 1'b1) begin
      if (inflight && cur.wr && cyc == cur.ack_at) refmem[cur.addr] = cur.wdata;
      if (inflight && cyc >= cur.ack_at + 2) inflight = 0;
      creq = cpu_rd | cpu_wr;
      lreq = ld_rd | ld_wr;
      if (!inflight && (creq || lreq)) begin
        who        = (creq && lreq) ? ~last_owner_m : lreq;
        cur.who    = who;
        cur.ack_at = cyc + 2;
        cur.wr     = who ? ld_wr : cpu_wr;
        cur.addr   = who ? ld_addr : cpu_addr;
        cur.wdata  = who ? ld_wdata : cpu_wdata;
        if (cur.wr) cur.rdata = last_rd_m;
        else begin
          cur.rdata = refmem[cur.addr];
          last_rd_m = cur.rdata;
        end
        last_owner_m = who;
        inflight     = 1;
        sbq.push_back(cur);
      end
    end
  end

  // Reset abandons any access in flight and restores the arbitration history.
  initial forever begin
    @(negedge rst_);
    sbq.delete();
    inflight     = 0;
    last_owner_m = 1'b1;
    last_rd_m    = 8'h00;
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    bit   have;
    @(negedge clk);
    have = (sbq.size() > 0);
    if (have) e = sbq[0];
    chk("busy",    busy,    have);
    chk("mem_rd",  mem_rd,  have && !e.wr && cyc < e.ack_at);
    chk("mem_wr",  mem_wr,  have && e.wr && cyc == e.ack_at - 1);
    chk("cpu_ack", cpu_ack, have && cyc == e.ack_at && !e.who);
    chk("ld_ack",  ld_ack,  have && cyc == e.ack_at && e.who);
    if (have) begin
      chk("mem_addr",  mem_addr,  e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      if (cyc >= e.ack_at) begin
        chk("rdata", rdata, e.rdata);
        void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input bit who, input int maxc,
                          output int cnt, output int n_rd, output int n_wr);
    bit got = 0;
    cnt = 0; n_rd = 0; n_wr = 0;
    for (int i = 1; i <= maxc && !got; i++) begin
      @(negedge clk);
      n_rd += int'(mem_rd);
      n_wr += int'(mem_wr);
      if (who ? ld_ack : cpu_ack) begin
        got = 1;
        cnt = i;
      end
    end
    if (!got) chk(who ? "ld_ack_timeout" : "cpu_ack_timeout", 0, 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst_ = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst_ = 1'b1;
  endtask

  task automatic new_cpu();
    logic [1:0] t;
    t = 2'($urandom_range(1, 3));
    cpu_rd    = t[0];
    cpu_wr    = t[1];
    cpu_addr  = ($urandom_range(1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  task automatic new_ld();
    logic [1:0] t;
    t = 2'($urandom_range(1, 3));
    ld_rd    = t[0];
    ld_wr    = t[1];
    ld_addr  = ($urandom_range(1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
    ld_wdata = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt, nrd, nwr;
    int ack_cyc[4];
    bit ack_who[4];
    int nack;
    logic [7:0] v, old;

    rst_ = 1'b0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_rd = 0;  ld_wr = 0;  ld_addr = '0;  ld_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      v = 8'($urandom);
      tbmem[i] = v;
      refmem[i] = v;
    end
    tbmem[5] = 8'hA7; refmem[5] = 8'hA7;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acks", {cpu_ack, ld_ack, mem_rd, mem_wr}, 0);
    #2 rst_ = 1'b1;

    // CPU read of address 5
    @(negedge clk);
    cpu_rd = 1; cpu_addr = 5;
    wait_ack(0, 10, cnt, nrd, nwr);
    chk("cpu_rd_latency", cnt, 3);
    chk("cpu_rd_strobes", nrd, 2);
    chk("cpu_rd_data", rdata, 8'hA7);
    chk("cpu_rd_no_ld_ack", ld_ack, 0);
    cpu_rd = 0;

    // Loader write to 31, then CPU read back
    @(negedge clk);
    ld_wr = 1; ld_addr = 31; ld_wdata = 8'h3C;
    wait_ack(1, 10, cnt, nrd, nwr);
    chk("ld_wr_strobes", nwr, 1);
    chk("ld_wr_no_rd", nrd, 0);
    ld_wr = 0;
    cpu_rd = 1; cpu_addr = 31;
    wait_ack(0, 12, cnt, nrd, nwr);
    chk("readback_31", rdata, 8'h3C);
    cpu_rd = 0;

    // rd and wr together is a write
    @(negedge clk);
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 3; cpu_wdata = 8'h55;
    wait_ack(0, 10, cnt, nrd, nwr);
    chk("rdwr_no_mem_rd", nrd, 0);
    chk("rdwr_one_mem_wr", nwr, 1);
    cpu_rd = 1; cpu_wr = 0;
    wait_ack(0, 12, cnt, nrd, nwr);
    chk("rdwr_readback", rdata, 8'h55);
    cpu_rd = 0;

    // Randomized traffic from both requesters
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        if ($urandom_range(1) == 0) begin cpu_rd = 0; cpu_wr = 0; end
        else new_cpu();
      end else if (!(cpu_rd | cpu_wr) && $urandom_range(9) < 4) new_cpu();
      if (ld_ack) begin
        if ($urandom_range(1) == 0) begin ld_rd = 0; ld_wr = 0; end
        else new_ld();
      end else if (!(ld_rd | ld_wr) && $urandom_range(9) < 4) new_ld();
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cpu_ack) begin cpu_rd = 0; cpu_wr = 0; end
      if (ld_ack)  begin ld_rd = 0;  ld_wr = 0;  end
      if (!(cpu_rd | cpu_wr | ld_rd | ld_wr) && !busy && sbq.size() == 0) break;
    end
    chk("drain_idle", {cpu_rd, cpu_wr, ld_rd, ld_wr, busy}, 0);

    // Tie after reset: CPU, loader, CPU, loader, 4 cycles apart
    do_reset(2);
    @(negedge clk);
    cpu_rd = 1; cpu_addr = 1;
    ld_rd = 1;  ld_addr = 2;
    nack = 0;
    for (int c = 0; c < 30 && nack < 4; c++) begin
      @(negedge clk);
      if (cpu_ack || ld_ack) begin
        ack_cyc[nack] = cyc;
        ack_who[nack] = ld_ack;
        nack++;
      end
    end
    cpu_rd = 0; ld_rd = 0;
    chk("tie_ack_count", nack, 4);
    for (int i = 0; i < 4; i++) begin
      chk("tie_order", ack_who[i], i % 2);
      if (i > 0) chk("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    end

    // Mid-access disturbance: CPU drops request, loader changes address
    repeat (3) @(negedge clk);
    cpu_rd = 1; cpu_addr = 7;
    @(negedge clk);
    chk("dist_busy", busy, 1);
    cpu_rd = 0;
    ld_rd = 1; ld_addr = 9;
    @(negedge clk);
    ld_addr = 10;
    wait_ack(0, 5, cnt, nrd, nwr);
    chk("dist_cpu_ack", cnt, 1);
    wait_ack(1, 10, cnt, nrd, nwr);
    chk("dist_ld_gap", cnt, 4);
    ld_rd = 0;

    // Reset during DATA of a write aborts it; pending loader read then served
    repeat (2) @(negedge clk);
    old = refmem[12];
    cpu_wr = 1; cpu_addr = 12; cpu_wdata = ~old;
    @(negedge clk);
    ld_rd = 1; ld_addr = 12;
    for (int c = 0; c < 5 && !mem_wr; c++) @(negedge clk);
    chk("abort_in_data", mem_wr, 1);
    #2 rst_ = 1'b0;
    cpu_wr = 0;
    #1;
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {cpu_ack, ld_ack}, 0);
    @(negedge clk);
    #2 rst_ = 1'b1;
    wait_ack(1, 10, cnt, nrd, nwr);
    chk("post_reset_latency", cnt, 3);
    chk("abort_mem_kept", tbmem[12], old);
    chk("post_reset_rdata", rdata, old);
    ld_rd = 0;

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
